// File: rtl/hex_display_if.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_if
// Brief    : Write handshake between the CPU result port and the display engine
// Revision : 1.0 - initial release
// ============================================================================
interface hex_display_if;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic        wr_ready;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface
`default_nettype wire

// File: rtl/hex_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_ctrl
// Brief    : 16-bit binary to four-digit active-low 7-segment display, via a
//            one-shift-per-clock double-dabble with atomic digit commit
// Revision : 1.0 - initial release
// ============================================================================
module hex_display_ctrl #(
    parameter int LZ_BLANK = 0
) (
    input  logic          clk,
    input  logic          rst,
    hex_display_if.slave  bus,
    input  logic          blank,
    output logic          ovf,
    output logic [6:0]    HEX3,
    output logic [6:0]    HEX2,
    output logic [6:0]    HEX1,
    output logic [6:0]    HEX0
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_CONVERT = 2'd1;
    localparam logic [1:0] c_COMMIT  = 2'd2;

    localparam logic [6:0] c_SEG_OFF  = 7'h7F;
    localparam logic [6:0] c_SEG_DASH = 7'h3F;

    logic [1:0]  r_state;
    logic [15:0] r_bin;
    logic [19:0] r_bcd;
    logic [4:0]  r_cnt;
    logic [6:0]  r_hex3, r_hex2, r_hex1, r_hex0;
    logic        r_ovf;

    logic [19:0] w_bcd_adj;
    logic [6:0]  w_hex3, w_hex2, w_hex1, w_hex0;
    logic        w_ovf;

    function automatic logic [6:0] f_seg(input logic [3:0] n);
        case (n)
            4'd0:    f_seg = 7'h40;
            4'd1:    f_seg = 7'h79;
            4'd2:    f_seg = 7'h24;
            4'd3:    f_seg = 7'h30;
            4'd4:    f_seg = 7'h19;
            4'd5:    f_seg = 7'h12;
            4'd6:    f_seg = 7'h02;
            4'd7:    f_seg = 7'h78;
            4'd8:    f_seg = 7'h00;
            4'd9:    f_seg = 7'h10;
            default: f_seg = c_SEG_OFF;
        endcase
    endfunction

    // Double-dabble correction: any nibble >= 5 would overflow a decimal digit on the next shift
    for (genvar i = 0; i < 5; i++) begin : g_adj
        assign w_bcd_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3
                                                              : r_bcd[4*i +: 4];
    end

    always_comb begin
        w_ovf  = (r_bcd[19:16] != 4'd0);
        w_hex3 = f_seg(r_bcd[15:12]);
        w_hex2 = f_seg(r_bcd[11:8]);
        w_hex1 = f_seg(r_bcd[7:4]);
        w_hex0 = f_seg(r_bcd[3:0]);
        if (w_ovf) begin
            w_hex3 = c_SEG_DASH;
            w_hex2 = c_SEG_DASH;
            w_hex1 = c_SEG_DASH;
            w_hex0 = c_SEG_DASH;
        end else if (LZ_BLANK != 0) begin
            if (r_bcd[15:12] == 4'd0) w_hex3 = c_SEG_OFF;
            if (r_bcd[15:8]  == 8'd0) w_hex2 = c_SEG_OFF;
            if (r_bcd[15:4]  == 12'd0) w_hex1 = c_SEG_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_bin   <= 16'd0;
            r_bcd   <= 20'd0;
            r_cnt   <= 5'd0;
            r_hex3  <= c_SEG_OFF;
            r_hex2  <= c_SEG_OFF;
            r_hex1  <= c_SEG_OFF;
            r_hex0  <= c_SEG_OFF;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.wr_valid) begin
                        r_bin   <= bus.wr_data;
                        r_bcd   <= 20'd0;
                        r_cnt   <= 5'd0;
                        r_state <= c_CONVERT;
                    end
                end
                c_CONVERT: begin
                    r_bcd <= {w_bcd_adj[18:0], r_bin[15]};
                    r_bin <= {r_bin[14:0], 1'b0};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd15) r_state <= c_COMMIT;
                end
                c_COMMIT: begin
                    r_hex3  <= w_hex3;
                    r_hex2  <= w_hex2;
                    r_hex1  <= w_hex1;
                    r_hex0  <= w_hex0;
                    r_ovf   <= w_ovf;
                    r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.wr_ready = (r_state == c_IDLE);
    assign ovf  = r_ovf;
    assign HEX3 = blank ? c_SEG_OFF : r_hex3;
    assign HEX2 = blank ? c_SEG_OFF : r_hex2;
    assign HEX1 = blank ? c_SEG_OFF : r_hex1;
    assign HEX0 = blank ? c_SEG_OFF : r_hex0;

endmodule
`default_nettype wire

// File: tb/tb_hex_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_display_ctrl
// Brief    : Scoreboard bench for hex_display_ctrl, one instance per LZ_BLANK
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_display_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hex_display_if if0();
    hex_display_if if1();

    logic       blank0, blank1;
    logic       ovf0, ovf1;
    logic [6:0] h03, h02, h01, h00;
    logic [6:0] h13, h12, h11, h10;

    hex_display_ctrl #(.LZ_BLANK(0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave), .blank(blank0), .ovf(ovf0),
        .HEX3(h03), .HEX2(h02), .HEX1(h01), .HEX0(h00)
    );

    hex_display_ctrl #(.LZ_BLANK(1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave), .blank(blank1), .ovf(ovf1),
        .HEX3(h13), .HEX2(h12), .HEX1(h11), .HEX0(h10)
    );

    int checks = 0;
    int errors = 0;

    logic [28:0] q0[$];
    logic [28:0] q1[$];
    logic [28:0] last0, last1;

    localparam logic [28:0] c_BLANK_DISP = {{4{7'h7F}}, 1'b0};
    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Display packed as {HEX3, HEX2, HEX1, HEX0, ovf}
    function automatic logic [28:0] model(input int v, input bit lz);
        logic [6:0] d3, d2, d1, d0;
        int n3, n2, n1, n0;
        if (v > 9999) return {{4{7'h3F}}, 1'b1};
        n3 = (v / 1000) % 10;
        n2 = (v / 100) % 10;
        n1 = (v / 10) % 10;
        n0 = v % 10;
        d3 = seg_tab[n3];
        d2 = seg_tab[n2];
        d1 = seg_tab[n1];
        d0 = seg_tab[n0];
        if (lz) begin
            if (n3 == 0) d3 = 7'h7F;
            if (n3 == 0 && n2 == 0) d2 = 7'h7F;
            if (n3 == 0 && n2 == 0 && n1 == 0) d1 = 7'h7F;
        end
        return {d3, d2, d1, d0, 1'b0};
    endfunction

    function automatic logic [28:0] disp(input bit sel);
        return sel ? {h13, h12, h11, h10, ovf1} : {h03, h02, h01, h00, ovf0};
    endfunction

    function automatic logic rdy(input bit sel);
        return sel ? if1.wr_ready : if0.wr_ready;
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [15:0] d);
        if (sel) begin
            if1.wr_valid = v;
            if1.wr_data  = d;
        end else begin
            if0.wr_valid = v;
            if0.wr_data  = d;
        end
    endtask

    // Called just after an edge; returns just after the accepting edge E0
    task automatic accept(input bit sel, input int v);
        int n = 0;
        while (!rdy(sel) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_before_accept", {31'd0, rdy(sel)}, 32'd1);
        drive(sel, 1'b1, v[15:0]);
        if (sel) q1.push_back(model(v, 1'b1));
        else     q0.push_back(model(v, 1'b0));
        @(posedge clk); #1;
        drive(sel, 1'b0, v[15:0]);
        chk("ready_low_E0", {31'd0, rdy(sel)}, 32'd0);
    endtask

    // Edges E1..E17; optional spurious write asserted after edge is and dropped after edge ie
    task automatic finish(input bit sel, input int is, input int ie, input logic [15:0] idata);
        logic [28:0] exp;
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk); #1;
            chk($sformatf("ready_low_E%0d", e), {31'd0, rdy(sel)}, 32'd0);
            chk($sformatf("hold_E%0d", e), {3'd0, disp(sel)}, {3'd0, sel ? last1 : last0});
            if (e == is) drive(sel, 1'b1, idata);
            if (e == ie) drive(sel, 1'b0, idata);
        end
        @(posedge clk); #1;
        chk("ready_high_E17", {31'd0, rdy(sel)}, 32'd1);
        if ((sel ? q1.size() : q0.size()) == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            exp = sel ? q1.pop_front() : q0.pop_front();
            chk("commit_display", {3'd0, disp(sel)}, {3'd0, exp});
            if (sel) last1 = exp;
            else     last0 = exp;
        end
    endtask

    task automatic send(input bit sel, input int v);
        accept(sel, v);
        finish(sel, 0, 0, 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        blank0 = 1'b0;
        blank1 = 1'b0;
        drive(1'b0, 1'b0, 16'd0);
        drive(1'b1, 1'b0, 16'd0);
        last0 = c_BLANK_DISP;
        last1 = c_BLANK_DISP;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_disp0", {3'd0, disp(1'b0)}, {3'd0, c_BLANK_DISP});
        chk("reset_disp1", {3'd0, disp(1'b1)}, {3'd0, c_BLANK_DISP});
        chk("reset_ready0", {31'd0, rdy(1'b0)}, 32'd1);
        chk("reset_ready1", {31'd0, rdy(1'b1)}, 32'd1);

        send(1'b0, 1234);
        send(1'b0, 9999);
        send(1'b0, 10000);
        send(1'b0, 65535);

        // blank must not mask ovf
        blank0 = 1'b1; #1;
        chk("blank_keeps_ovf", {3'd0, disp(1'b0)}, {3'd0, {{4{7'h7F}}, 1'b1}});
        blank0 = 1'b0; #1;

        // 42 offered mid-conversion (sampled on E5..E7) must be ignored
        accept(1'b0, 7);
        finish(1'b0, 4, 7, 16'd42);
        send(1'b0, 42);

        // Reset on E8 aborts the conversion of 8888
        accept(1'b0, 8888);
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q0.delete();
        last0 = c_BLANK_DISP;
        last1 = c_BLANK_DISP;
        chk("abort_disp", {3'd0, disp(1'b0)}, {3'd0, c_BLANK_DISP});
        chk("abort_ready", {31'd0, rdy(1'b0)}, 32'd1);

        send(1'b0, 5678);
        blank0 = 1'b1; #1;
        chk("blank_on", {3'd0, disp(1'b0)}, {3'd0, c_BLANK_DISP});
        blank0 = 1'b0; #1;
        chk("blank_off", {3'd0, disp(1'b0)}, {3'd0, {7'h12, 7'h02, 7'h78, 7'h00, 1'b0}});

        send(1'b1, 5);
        send(1'b1, 0);
        send(1'b1, 1005);
        send(1'b1, 10000);
        send(1'b1, 9999);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
